// File: rtl/exec_dispatch.sv
// exec_dispatch: execute-stage controller. Issues decoded ops to NUM_UNITS
// functional units and tracks them in an in-order completion queue. Only the
// oldest op may complete, so results retire in program order into a
// registered writeback output.
// Optional build macro EXEC_DISPATCH_BYPASS_EN: forwards the output register
// to the rs1/rs2 operands. Without it, a match on the output register's rd
// stalls the op instead.
module exec_dispatch #(
    parameter int NUM_UNITS    = 3,
    parameter int MAX_INFLIGHT = 4,
    parameter int DATA_W       = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_UNITS-1:0]        in_unit_sel,
    input  logic                        in_exception,
    input  logic                        in_is_reg_write,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [DATA_W-1:0]           in_rs1_data,
    input  logic [DATA_W-1:0]           in_rs2_data,
    output logic [NUM_UNITS-1:0]        unit_issue_valid,
    input  logic [NUM_UNITS-1:0]        unit_issue_ready,
    output logic [DATA_W-1:0]           op_rs1_data,
    output logic [DATA_W-1:0]           op_rs2_data,
    input  logic [NUM_UNITS-1:0]        unit_result_valid,
    output logic [NUM_UNITS-1:0]        unit_result_ready,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_result_data,
    input  logic [NUM_UNITS-1:0]        unit_result_exception,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic                        out_exception,
    output logic                        out_is_reg_write,
    output logic [4:0]                  out_rd
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [UW-1:0] unit;
        logic          exc;
        logic          rw;
        logic [4:0]    rd;
    } entry_t;

    entry_t                  q_mem [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] q_vld;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    stopped;

    entry_t              head;
    logic                q_empty;
    logic                q_full;
    logic [UW-1:0]       sel_idx;
    logic                sel_ready;
    logic                hazard;
    logic                accept;
    logic                can_load;
    logic                complete;
    logic                res_exc;
    logic [DATA_W-1:0]   head_data;

    assign head      = q_mem[rd_ptr];
    assign q_empty   = (count == '0);
    assign q_full    = (count == CW'(MAX_INFLIGHT));
    assign sel_ready = |(in_unit_sel & unit_issue_ready);

    // One-hot unit select to queue index
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (in_unit_sel[i]) sel_idx = UW'(i);
        end
    end

    // RAW hazard against every queued writer (and the output register when not forwarding)
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (q_vld[i] && q_mem[i].rw &&
                ((in_rs1 != 5'd0 && in_rs1 == q_mem[i].rd) ||
                 (in_rs2 != 5'd0 && in_rs2 == q_mem[i].rd)))
                hazard = 1'b1;
        end
`ifndef EXEC_DISPATCH_BYPASS_EN
        if (out_valid && out_is_reg_write &&
            ((in_rs1 != 5'd0 && in_rs1 == out_rd) ||
             (in_rs2 != 5'd0 && in_rs2 == out_rd)))
            hazard = 1'b1;
`endif
    end

    assign in_ready = !rst && !flush && !stopped && !q_full && !hazard &&
                      (in_exception || sel_ready);
    assign accept   = in_valid && in_ready;
    assign unit_issue_valid = {NUM_UNITS{accept && !in_exception}} & in_unit_sel;

    // The head may complete when the output register is free or being drained this cycle
    assign can_load  = !rst && !flush && !q_empty && (!out_valid || out_ready);
    assign complete  = can_load && (head.exc || unit_result_valid[head.unit]);
    assign res_exc   = !head.exc && unit_result_exception[head.unit];
    assign head_data = unit_result_data[head.unit*DATA_W +: DATA_W];

    // Only the head unit is ever acknowledged; younger units hold their results
    always_comb begin
        unit_result_ready = '0;
        if (can_load && !head.exc) unit_result_ready[head.unit] = 1'b1;
    end

`ifdef EXEC_DISPATCH_BYPASS_EN
    assign op_rs1_data = (out_valid && out_is_reg_write && in_rs1 != 5'd0 && in_rs1 == out_rd)
                         ? out_result : in_rs1_data;
    assign op_rs2_data = (out_valid && out_is_reg_write && in_rs2 != 5'd0 && in_rs2 == out_rd)
                         ? out_result : in_rs2_data;
`else
    assign op_rs1_data = in_rs1_data;
    assign op_rs2_data = in_rs2_data;
`endif

    // Queue payload storage; needs no reset since q_vld qualifies every entry
    always_ff @(posedge clk) begin
        if (accept) begin
            q_mem[wr_ptr] <= '{unit: sel_idx, exc: in_exception,
                               rw: in_is_reg_write, rd: in_rd};
        end
    end

    // Queue pointers, occupancy and the exception stop flag
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q_vld   <= '0;
            stopped <= 1'b0;
        end else begin
            if (accept) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (complete) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count <= count + CW'(accept) - CW'(complete);
            if ((accept && in_exception) || (complete && res_exc))
                stopped <= 1'b1;
        end
    end

    // Writeback output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_exception    <= 1'b0;
            out_is_reg_write <= 1'b0;
            out_rd           <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid        <= 1'b1;
            out_result       <= head.exc ? '0 : head_data;
            out_exception    <= head.exc || res_exc;
            out_is_reg_write <= head.rw && !head.exc && !res_exc;
            out_rd           <= head.rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/exec_dispatch.md
# exec_dispatch

Parametrised execute-stage controller between decode and writeback. It issues decoded ops to `NUM_UNITS` functional units over valid/ready, tracks up to `MAX_INFLIGHT` outstanding ops in an in-order completion queue, and retires unit results strictly in program order into a registered output. It also provides rs1/rs2 bypass, stalls on RAW hazards, handles exception stop and pipeline flush. It generalises the fixed branch/int/mem exec stage to any number of units with multiple ops in flight.

## Interface
Parameters:
- `NUM_UNITS`, 3, number of functional units (≥2)
- `MAX_INFLIGHT`, 4, completion-queue depth (power of 2, ≥2)
- `DATA_W`, 64, result/operand width

Ports:
- `clk`  in  1  clock, single domain
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush (mispredict/trap)
- `in_valid`  in  1  decoded op available
- `in_ready`  out  1  op accepted when `in_valid && in_ready`
- `in_unit_sel`  in  NUM_UNITS  one-hot target unit (ignored if `in_exception`)
- `in_exception`  in  1  decode-stage exception, no unit issue
- `in_is_reg_write`  in  1  op writes `in_rd`
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register selectors
- `in_rs1_data`, `in_rs2_data`  in  DATA_W  register-file operands
- `unit_issue_valid`  out  NUM_UNITS  per-unit issue strobe
- `unit_issue_ready`  in  NUM_UNITS  unit can accept
- `op_rs1_data`, `op_rs2_data`  out  DATA_W  bypassed operands, shared by all units
- `unit_result_valid`  in  NUM_UNITS  unit has a result
- `unit_result_ready`  out  NUM_UNITS  result consumed
- `unit_result_data`  in  NUM_UNITS*DATA_W  unit i at `[i*DATA_W +: DATA_W]`
- `unit_result_exception`  in  NUM_UNITS  result raised exception
- `out_valid`, `out_ready`  out/in  1  writeback handshake
- `out_result`  out  DATA_W;  `out_exception`  out  1;  `out_is_reg_write`  out  1;  `out_rd`  out  5

## Operation
- Queue entry: {unit index, exception, is_reg_write, rd}. Pushed on an accepted op; popped when its result moves into the output register.
- `in_ready` = !rst && !flush && !stopped && queue not full && !hazard && (`in_exception` || `unit_issue_ready` of the selected unit).
- `unit_issue_valid[i]` = `in_valid && in_ready && !in_exception && in_unit_sel[i]` (combinational).
- Completion: the head entry is the only one eligible. `unit_result_ready[head.unit]` = queue not empty && !head.exception && !flush && (!`out_valid` || `out_ready`). All other bits are 0, so younger unit results are held by their units.
- An exception head entry completes without unit involvement. It loads `out_exception`=1 and `out_result`=0.
- `stopped` is set when an exception is accepted or a unit result has exception=1. It stays set until `flush`. While `stopped`, no further ops are accepted.
- Hazard: `in_rs1`/`in_rs2` (≠0) matches the rd of any queue entry with is_reg_write=1. Entries count while queued. The output register's rd counts too, but only when bypass is compiled out.
- `out_is_reg_write` is forced to 0 when `out_exception`=1.
- `unit_result_valid` on a unit that is not the head unit is legal and ignored.

## Timing
- Reset values: `out_valid`=0, `out_exception`=0, `out_is_reg_write`=0, `out_rd`=0, `out_result`=0, queue empty, `stopped`=0.
- Issue has zero latency (same cycle as the accept). Head result handshake to `out_valid`=1 takes 1 cycle. Minimum accept-to-`out_valid` is unit latency + 1.
- Output register holds its value while `out_valid && !out_ready`. A new completion can load in the same cycle that `out_ready` retires the old value, giving full throughput.
- Queue full: `in_ready`=0. A simultaneous pop and push at full is not allowed in that cycle, because `in_ready` is computed from the registered count.
- `flush`: in the next cycle the queue is empty, `out_valid`=0 and `stopped`=0. During the flush cycle no accept and no completion happen. Units clear themselves on `flush`.
- Reset asserted mid-operation: all state returns to the reset values on the next edge and all handshakes are deasserted during reset.

## Configuration
- `EXEC_DISPATCH_BYPASS_EN`
  - Defined: when `out_valid && out_is_reg_write && out_rd==rsN && rsN≠0`, `op_rsN_data` = `out_result`. Otherwise it is `in_rsN_data`.
  - Undefined: `op_rsN_data` = `in_rsN_data`, and a match on the output register is treated as a hazard (stall).

## Test plan
- Int op rd=5, unit latency 2, `out_ready`=1 → `out_valid` 3 cycles after accept with `out_rd`=5. Then a dependent op rs1=5 → bypass value with EN defined; stall until retire without it.
- Ops to units 0,1,2 issued back-to-back, unit 2 answers first → results appear in order 0,1,2; `unit_result_ready[2]` stays 0 until unit 2 is at the head.
- Four long-latency ops (`MAX_INFLIGHT`=4) → `in_ready`=0 on the fifth until the first completes.
- `out_ready`=0 for 5 cycles with a result pending → `out_*` stable and the head unit stalled; on release, throughput is 1 result per cycle.
- `in_exception`=1 accepted → `out_exception`=1, `out_is_reg_write`=0; later ops are refused until `flush`, then accepted.
- `flush` with 3 ops queued and `out_valid`=1 → next cycle `out_valid`=0 and queue empty; a new op is accepted in the following cycle.
